// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter sharing the register file's single write
// port among NUM_REQ writeback sources. The winning request is registered and
// driven onto the regfile load/dest/in one cycle after the handshake. Writes to
// x0 are granted but suppressed at the output stage. A combinational query
// reports whether a register still has a write in flight.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*5-1:0]    req_dest,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rf_load,
    output logic [4:0]              rf_dest,
    output logic [31:0]             rf_in,
    input  logic [4:0]              query_reg,
    output logic                    query_hit,
    output logic                    idle
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NREQ    = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] ptr;

    // Per-requester views of the packed dest/data buses
    logic        [4:0]  dest_p0 [NUM_REQ];
    logic signed [31:0] data_p0 [NUM_REQ];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign dest_p0[g] = req_dest[g*5 +: 5];
            assign data_p0[g] = req_data[g*32 +: 32];
        end
    endgenerate

    logic [NUM_REQ-1:0] grant_p0;
    logic [PTR_W-1:0]   gidx_p0;
    logic               found_p0;
    logic               vld_p0;
    logic [4:0]         sel_dest_p0;
    logic signed [31:0] sel_data_p0;

    // Round-robin scan starting at ptr; the first valid requester wins
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        grant_p0 = '0;
        gidx_p0  = '0;
        found_p0 = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(j);
            if (sum >= NREQ) sum = sum - NREQ;
            idx = sum[PTR_W-1:0];
            if (!found_p0 && req_valid[idx]) begin
                grant_p0[idx] = 1'b1;
                gidx_p0       = idx;
                found_p0      = 1'b1;
            end
        end
    end

    assign vld_p0      = found_p0 && !hold && !rst;
    assign req_ready   = vld_p0 ? grant_p0 : '0;
    assign sel_dest_p0 = dest_p0[gidx_p0];
    assign sel_data_p0 = data_p0[gidx_p0];

    // ---- stage boundary: granted write registered onto the regfile port ----
    logic               vld_p1;
    logic [4:0]         dest_p1;
    logic signed [31:0] data_p1;

    // Output register and pointer update; x0 writes are granted but never loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            dest_p1 <= '0;
            data_p1 <= '0;
            ptr     <= '0;
        end else begin
            vld_p1 <= vld_p0 && (sel_dest_p0 != 5'd0);
            if (vld_p0 && (sel_dest_p0 != 5'd0)) begin
                dest_p1 <= sel_dest_p0;
                data_p1 <= sel_data_p0;
            end
            if (vld_p0) begin
                ptr <= (gidx_p0 == LAST_IX) ? '0 : gidx_p0 + 1'b1;
            end
        end
    end

    assign rf_load = vld_p1;
    assign rf_dest = dest_p1;
    assign rf_in   = data_p1;

    // Pending-write lookup over both the request side and the output stage
    always_comb begin
        logic hit;
        hit = vld_p1 && (dest_p1 == query_reg);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && (dest_p0[i] == query_reg)) hit = 1'b1;
        end
        query_hit = (query_reg != 5'd0) && hit;
    end

    assign idle = ~|req_valid & ~vld_p1;

endmodule
